// File: rtl/i2c_xfer_sched.sv
// i2c_xfer_sched: round-robin scheduler sharing one I2C master core and its TX/RX FIFOs
// among NREQ requesters.
//
// For each granted request the block latches the address/R-W byte, byte count and SCL
// divider into the core configuration outputs. It then streams write bytes from the owner
// into the TX FIFO and pulses core_start. Read bytes are returned from the RX FIFO to the
// owner, and a done pulse (with err on timeout) ends the transaction.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_addr_rw/req_cnt request side, one lane of 8 bits per requester
//   req_ready                     one-cycle grant pulse
//   wr_data/wr_valid/wr_ready     per-requester write byte stream
//   rd_data/rd_valid              read byte to the owner (one-hot valid, no backpressure)
//   done/err                      completion pulse to the owner; err = timeout abort
//   cfg_div                       SCL divider, sampled at grant
//   core_addr_rw/core_cnt/core_div, core_start, core_done   I2C core control
//   txff_wr/txff_data/txff_full   TX FIFO write side
//   rxff_rd/rxff_data/rxff_empty  RX FIFO read side (data valid the cycle after rxff_rd)
module i2c_xfer_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_addr_rw,
    input  logic [8*NREQ-1:0]   req_cnt,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   wr_data,
    input  logic [NREQ-1:0]     wr_valid,
    output logic [NREQ-1:0]     wr_ready,
    output logic [7:0]          rd_data,
    output logic [NREQ-1:0]     rd_valid,
    output logic [NREQ-1:0]     done,
    output logic                err,
    input  logic [15:0]         cfg_div,
    output logic [7:0]          core_addr_rw,
    output logic [7:0]          core_cnt,
    output logic [15:0]         core_div,
    output logic                core_start,
    input  logic                core_done,
    output logic                txff_wr,
    output logic [7:0]          txff_data,
    input  logic                txff_full,
    output logic                rxff_rd,
    input  logic [7:0]          rxff_data,
    input  logic                rxff_empty
);

    localparam int unsigned OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef logic [OW-1:0] own_t;

    typedef enum logic [2:0] {
        StIdle, StGrant, StLoad, StStart, StWait, StDrain, StFin
    } state_e;

    state_e      state_q, state_d;
    own_t        owner_q, owner_d;
    own_t        rr_ptr_q, rr_ptr_d;
    logic [7:0]  addr_rw_q, addr_rw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  left_q, left_d;
    logic [15:0] tmo_q, tmo_d;
    logic        rd_pend_q, rd_pend_d;
    logic        err_q, err_d;
    logic        core_start_q, core_start_d;

    own_t        win_idx;
    logic        is_read;
    logic        push_en;
    logic        pull_en;
    logic        wr_ok;

    assign core_addr_rw = addr_rw_q;
    assign core_cnt     = cnt_q;
    assign core_div     = div_q;
    // Registered from the START state, so the pulse lands in the first WAIT cycle.
    assign core_start   = core_start_q;

    // Round-robin pick: scanning downward leaves the requester closest to rr_ptr as winner.
    always_comb begin
        win_idx = rr_ptr_q;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr_q) + i) % int'(NREQ)]) begin
                win_idx = own_t'((int'(rr_ptr_q) + i) % int'(NREQ));
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        addr_rw_d    = addr_rw_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        left_d       = left_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        req_ready    = '0;
        wr_ready     = '0;
        rd_valid     = '0;
        rd_data      = '0;
        done         = '0;
        err          = 1'b0;
        txff_wr      = 1'b0;
        txff_data    = '0;
        rxff_rd      = 1'b0;
        wr_ok        = 1'b0;

        is_read = addr_rw_q[0];
        push_en = (state_q == StLoad) || ((state_q == StWait) && !is_read);
        pull_en = ((state_q == StWait) || (state_q == StDrain)) && is_read;

        if (push_en) begin
            wr_ok             = !txff_full && (left_q != 8'd0);
            wr_ready[owner_q] = wr_ok;
            if (wr_ok && wr_valid[owner_q]) begin
                txff_wr   = 1'b1;
                txff_data = wr_data[int'(owner_q)*8 +: 8];
                left_d    = left_q - 8'd1;
            end
        end

        if (pull_en) begin
            // Only one read in flight: the next read waits for the previous byte to land.
            rxff_rd = !rxff_empty && (left_q != 8'd0) && !rd_pend_q;
            if (rd_pend_q && (left_q != 8'd0)) begin
                rd_valid[owner_q] = 1'b1;
                rd_data           = rxff_data;
                left_d            = left_q - 8'd1;
            end
        end

        rd_pend_d    = rxff_rd;
        core_start_d = (state_q == StStart);

        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d   = StGrant;
                    owner_d   = win_idx;
                    addr_rw_d = req_addr_rw[int'(win_idx)*8 +: 8];
                    cnt_d     = req_cnt[int'(win_idx)*8 +: 8];
                    left_d    = req_cnt[int'(win_idx)*8 +: 8];
                    div_d     = cfg_div;
                    err_d     = 1'b0;
                end
            end
            StGrant: begin
                req_ready[owner_q] = 1'b1;
                state_d = (!is_read && (left_q != 8'd0)) ? StLoad : StStart;
            end
            StLoad: begin
                // Start early on a full FIFO so a shallow FIFO never stalls the core.
                if ((left_d == 8'd0) || txff_full) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + 16'd1;
                if (core_done) begin
                    state_d = (!is_read || (left_d == 8'd0)) ? StFin : StDrain;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StFin;
                    err_d   = 1'b1;
                end
            end
            StDrain: begin
                tmo_d = tmo_q + 16'd1;
                if (left_d == 8'd0) begin
                    state_d = StFin;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StFin;
                    err_d   = 1'b1;
                end
            end
            StFin: begin
                done[owner_q] = 1'b1;
                err           = err_q;
                rr_ptr_d      = (owner_q == own_t'(NREQ - 1)) ? '0 : owner_q + own_t'(1);
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            addr_rw_q    <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
            left_q       <= '0;
            tmo_q        <= '0;
            rd_pend_q    <= 1'b0;
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            addr_rw_q    <= addr_rw_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            left_q       <= left_d;
            tmo_q        <= tmo_d;
            rd_pend_q    <= rd_pend_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Self-checking bench for i2c_xfer_sched: table of single transactions plus hand-written
// arbitration and mid-transaction reset sequences. A cycle-stepped model of the TX/RX FIFOs,
// write sources and the I2C core drives the DUT; scoreboard queues hold expected grants,
// TX bytes, read bytes and done pulses.
module tb_i2c_xfer_sched;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 100;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_addr_rw;
    logic [8*NREQ-1:0]   req_cnt;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   wr_data;
    logic [NREQ-1:0]     wr_valid;
    logic [NREQ-1:0]     wr_ready;
    logic [7:0]          rd_data;
    logic [NREQ-1:0]     rd_valid;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [15:0]         cfg_div;
    logic [7:0]          core_addr_rw;
    logic [7:0]          core_cnt;
    logic [15:0]         core_div;
    logic                core_start;
    logic                core_done;
    logic                txff_wr;
    logic [7:0]          txff_data;
    logic                txff_full;
    logic                rxff_rd;
    logic [7:0]          rxff_data;
    logic                rxff_empty;

    i2c_xfer_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr_rw  (req_addr_rw),
        .req_cnt      (req_cnt),
        .req_ready    (req_ready),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .done         (done),
        .err          (err),
        .cfg_div      (cfg_div),
        .core_addr_rw (core_addr_rw),
        .core_cnt     (core_cnt),
        .core_div     (core_div),
        .core_start   (core_start),
        .core_done    (core_done),
        .txff_wr      (txff_wr),
        .txff_data    (txff_data),
        .txff_full    (txff_full),
        .rxff_rd      (rxff_rd),
        .rxff_data    (rxff_data),
        .rxff_empty   (rxff_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [7:0]  addr;
        logic [7:0]  cnt;
        logic [63:0] data;      // byte k in data[8k+:8]
        int          full_lim;  // txff_full rises once this many bytes were written
        int          full_rel;  // ...and drops this many cycles after core_start
        int          dly;       // core_done pulse this many cycles after core_start, 0 = never
        int          supply;    // RX bytes supplied by the core model
        int          gap;       // RX byte k appears at core_start + 2 + k*gap
        int          exp_start; // cycles from req_ready to core_start
        int          exp_done;  // cycles from core_start to done, -1 = not checked
        logic        exp_err;
    } vec_t;

    int tests;
    int fails;
    int cyc;
    logic [7:0]        wq[$];
    logic [7:0]        rxq[$];
    logic [7:0]        tx_exp[$];
    logic [NREQ+7:0]   rd_exp[$];
    logic [NREQ:0]     done_exp[$];
    logic [NREQ-1:0]   gnt_exp[$];
    int                gcyc_q[$];
    int                dcyc_q[$];
    logic [7:0]        exp_addr [NREQ];
    logic [7:0]        exp_cnt [NREQ];
    logic [15:0]       exp_div;
    logic [63:0]       rdat;
    logic [NREQ-1:0]   rearm;
    int wown;
    int full_lim;
    int full_rel;
    int dly;
    int supply;
    int supplied;
    int gap;
    int tx_written;
    int n_done;
    int s_cyc;
    int g_cyc;
    int d_cyc;
    logic started;
    vec_t vecs [7];

    function automatic logic [NREQ-1:0] oh(input int who);
        logic [NREQ-1:0] r;
        r      = '0;
        r[who] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_wr();
        wr_valid = '0;
        wr_data  = '0;
        if (wq.size() != 0) begin
            wr_valid[wown]         = 1'b1;
            wr_data[wown*8 +: 8]   = wq[0];
        end
    endtask

    task automatic request(input int who, input logic [7:0] a, input logic [7:0] c);
        exp_addr[who]           = a;
        exp_cnt[who]            = c;
        req_addr_rw[who*8 +: 8] = a;
        req_cnt[who*8 +: 8]     = c;
        req_valid[who]          = 1'b1;
    endtask

    // One clock: observe at the falling edge, then update the environment model after the
    // rising edge according to the handshakes that edge completed.
    task automatic tick();
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] wacc;
        logic            racc;
        int              gi;
        @(negedge clk);
        gnt  = req_ready;
        wacc = wr_valid & wr_ready;
        racc = rxff_rd;
        if (|gnt) begin
            g_cyc = cyc;
            gcyc_q.push_back(cyc);
            started    = 1'b0;
            tx_written = 0;
            supplied   = 0;
            gi = 0;
            for (int b = 0; b < int'(NREQ); b++) if (gnt[b]) gi = b;
            check("grant_expected", 32'(gnt_exp.size() != 0), 1);
            if (gnt_exp.size() != 0) check("grant_onehot", gnt, gnt_exp.pop_front());
            check("core_addr_rw", core_addr_rw, exp_addr[gi]);
            check("core_cnt", core_cnt, exp_cnt[gi]);
            check("core_div", core_div, exp_div);
        end
        if (core_start) begin
            started = 1'b1;
            s_cyc   = cyc;
        end
        if (txff_wr) begin
            check("no_wr_when_full", txff_full, 0);
            check("tx_expected", 32'(tx_exp.size() != 0), 1);
            if (tx_exp.size() != 0) check("txff_data", txff_data, tx_exp.pop_front());
            check("core_cnt_hold", core_cnt, exp_cnt[wown]);
        end
        if (rxff_rd) check("rd_not_empty", rxff_empty, 0);
        if (|rd_valid) begin
            check("rd_expected", 32'(rd_exp.size() != 0), 1);
            if (rd_exp.size() != 0) check("rd_valid_data", {rd_valid, rd_data}, rd_exp.pop_front());
        end
        if (err && !(|done)) check("err_without_done", err, 0);
        if (|done) begin
            d_cyc = cyc;
            dcyc_q.push_back(cyc);
            n_done++;
            started = 1'b0;
            check("done_expected", 32'(done_exp.size() != 0), 1);
            if (done_exp.size() != 0) check("done_err", {done, err}, done_exp.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (|wacc) begin
            if (wq.size() != 0) void'(wq.pop_front());
            tx_written++;
        end
        if (racc && (rxq.size() != 0)) rxff_data = rxq.pop_front();
        if (|gnt) begin
            req_valid = (req_valid & ~gnt) | (rearm & gnt);
            rearm     = rearm & ~gnt;
        end
        txff_full = (tx_written >= full_lim) && !(started && ((cyc - s_cyc) >= full_rel));
        core_done = started && (dly != 0) && ((cyc - s_cyc) == dly);
        if (started && (supplied < supply) && ((cyc - s_cyc) == 2 + supplied * gap)) begin
            rxq.push_back(rdat[supplied*8 +: 8]);
            rd_exp.push_back({oh(wown), rdat[supplied*8 +: 8]});
            supplied++;
        end
        rxff_empty = (rxq.size() == 0);
        drive_wr();
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n;
        n = 0;
        while ((n_done < target) && (n < budget)) begin
            tick();
            n++;
        end
        check({name, "_finished"}, 32'(n_done >= target), 1);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   target;
        v        = vecs[i];
        wown     = v.who;
        exp_div  = 16'h0100 + 16'(i);
        cfg_div  = exp_div;
        full_lim = v.full_lim;
        full_rel = v.full_rel;
        dly      = v.dly;
        supply   = v.supply;
        gap      = v.gap;
        rdat     = v.data;
        s_cyc    = -100000;
        g_cyc    = -100000;
        if (!v.addr[0]) begin
            for (int k = 0; k < int'(v.cnt); k++) begin
                wq.push_back(v.data[k*8 +: 8]);
                tx_exp.push_back(v.data[k*8 +: 8]);
            end
        end
        drive_wr();
        request(v.who, v.addr, v.cnt);
        gnt_exp.push_back(oh(v.who));
        done_exp.push_back({oh(v.who), v.exp_err});
        target = n_done + 1;
        run_until(target, 400, $sformatf("v%0d", i));
        check($sformatf("v%0d_start_lat", i), 32'(s_cyc - g_cyc), 32'(v.exp_start));
        if (v.exp_done >= 0) check($sformatf("v%0d_done_lat", i), 32'(d_cyc - s_cyc), 32'(v.exp_done));
        check($sformatf("v%0d_tx_left", i), 32'(tx_exp.size()), 0);
        check($sformatf("v%0d_rd_left", i), 32'(rd_exp.size()), 0);
        wq.delete();
        tx_exp.delete();
        rd_exp.delete();
        rxq.delete();
        drive_wr();
        tick();
        tick();
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; n_done = 0;
        rst = 1'b1; req_valid = '0; req_addr_rw = '0; req_cnt = '0;
        wr_data = '0; wr_valid = '0; cfg_div = '0; core_done = 1'b0;
        txff_full = 1'b0; rxff_data = '0; rxff_empty = 1'b1;
        rearm = '0; wown = 0; full_lim = 255; full_rel = 0; dly = 0;
        supply = 0; supplied = 0; gap = 0; tx_written = 0; started = 1'b0;
        s_cyc = 0; g_cyc = 0; d_cyc = 0; exp_div = '0; rdat = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            exp_addr[k] = '0;
            exp_cnt[k]  = '0;
        end

        //         who addr   cnt   data                    flim rel dly sup gap st  dn  err
        vecs[0] = '{0, 8'hA0, 8'd3, 64'h0000_0000_0033_2211, 255, 0, 20, 0, 0,    5, 21, 1'b0};
        vecs[1] = '{1, 8'hA1, 8'd2, 64'h0000_0000_0000_C35A, 255, 0, 8,  2, 12,   2, 16, 1'b0};
        vecs[2] = '{0, 8'hA4, 8'd8, 64'h0807_0605_0403_0201, 4,   3, 20, 0, 0,    7, 21, 1'b0};
        vecs[3] = '{1, 8'hB0, 8'd0, 64'h0,                   255, 0, 0,  0, 0,    2, 100, 1'b1};
        vecs[4] = '{0, 8'hB3, 8'd3, 64'h0000_0000_0000_0077, 255, 0, 0,  1, 1000, 2, 100, 1'b1};
        vecs[5] = '{1, 8'hC2, 8'd0, 64'h0,                   255, 0, 5,  0, 0,    2, 6,  1'b0};
        vecs[6] = '{0, 8'hC5, 8'd1, 64'h0000_0000_0000_009E, 255, 0, 4,  1, 1,    2, 5,  1'b0};

        @(posedge clk);
        #1;
        check("reset_outputs", {req_ready, wr_ready, rd_valid, done, err, core_start, txff_wr,
                                rxff_rd, txff_data, rd_data}, 0);
        check("reset_core_cfg", {core_addr_rw, core_cnt, core_div}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Arbitration: both valid after reset, req0 re-raised right after its grant.
        exp_div = 16'h0042; cfg_div = exp_div; dly = 3; full_lim = 255;
        gcyc_q.delete(); dcyc_q.delete();
        rearm = 2'b01;
        request(0, 8'h50, 8'd0);
        request(1, 8'h60, 8'd0);
        gnt_exp.push_back(2'b01); gnt_exp.push_back(2'b10); gnt_exp.push_back(2'b01);
        done_exp.push_back({2'b01, 1'b0});
        done_exp.push_back({2'b10, 1'b0});
        done_exp.push_back({2'b01, 1'b0});
        run_until(n_done + 3, 200, "arb");
        if (gcyc_q.size() >= 3 && dcyc_q.size() >= 2) begin
            check("arb_gap0", 32'(gcyc_q[1] - dcyc_q[0]), 2);
            check("arb_gap1", 32'(gcyc_q[2] - dcyc_q[1]), 2);
        end else begin
            check("arb_grant_count", 32'(gcyc_q.size()), 3);
        end
        tick();
        tick();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset while req1 is in LOAD; afterwards rr_ptr must be back at requester 0.
        wown = 1; full_lim = 255; dly = 0; supply = 0; exp_div = 16'h0777; cfg_div = exp_div;
        for (int k = 0; k < 8; k++) begin
            wq.push_back(8'hE0 + 8'(k));
            tx_exp.push_back(8'hE0 + 8'(k));
        end
        drive_wr();
        request(1, 8'h70, 8'd8);
        gnt_exp.push_back(2'b10);
        done_exp.push_back({2'b10, 1'b0});
        tx_written = 0;
        for (int n = 0; n < 20 && tx_written == 0; n++) tick();
        check("load_before_rst", wr_ready, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {req_ready, wr_ready, rd_valid, done, err, core_start, txff_wr,
                                  rxff_rd, txff_data, rd_data}, 0);
        check("rst_mid_core_cfg", {core_addr_rw, core_cnt, core_div}, 0);
        wq.delete(); tx_exp.delete(); done_exp.delete(); gnt_exp.delete();
        req_valid = '0; core_done = 1'b0; txff_full = 1'b0; started = 1'b0;
        drive_wr();
        tick();
        tick();
        tick();
        rst = 1'b0;
        exp_div = 16'h0033; cfg_div = exp_div; dly = 3;
        request(0, 8'h52, 8'd0);
        request(1, 8'h62, 8'd0);
        gnt_exp.push_back(2'b01); gnt_exp.push_back(2'b10);
        done_exp.push_back({2'b01, 1'b0});
        done_exp.push_back({2'b10, 1'b0});
        run_until(n_done + 2, 100, "post_rst");
        check("post_rst_grants_left", 32'(gnt_exp.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_xfer_sched.md
# i2c_xfer_sched

Round-robin transaction scheduler that shares one I2C master core and its TX/RX FIFOs among `NREQ` requesters. For each granted request it programs the address/R-W byte, byte count and clock divider, streams write bytes into the TX FIFO, and pulses the core's start. It then returns read bytes from the RX FIFO to the owner and signals completion or timeout. It sits between on-chip requesters and the core/FIFO datapath, in place of direct APB-driven sequencing.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `TIMEOUT`, 65535: cycles allowed in WAIT/DRAIN before abort; 16-bit counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  request pending; fields held stable until `req_ready`.
- `req_addr_rw`  in  8*NREQ  {addr[6:0], rw}; rw=1 read, 0 write.
- `req_cnt`  in  8*NREQ  data bytes, 0..255.
- `req_ready`  out  NREQ  one-cycle grant pulse.
- `wr_data`  in  8*NREQ  write byte stream.
- `wr_valid`  in  NREQ  write byte offered.
- `wr_ready`  out  NREQ  write byte accepted when valid & ready.
- `rd_data`  out  8  read byte.
- `rd_valid`  out  NREQ  one-hot to owner; no backpressure.
- `done`  out  NREQ  one-cycle completion pulse to owner.
- `err`  out  1  qualifies `done`: 1 = timeout abort.
- `cfg_div`  in  16  SCL divider sampled at grant.
- `core_addr_rw`  out  8, `core_cnt`  out  8, `core_div`  out  16  core configuration, held for the whole transaction.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_done`  in  1  core transaction complete.
- `txff_wr`  out  1, `txff_data`  out  8, `txff_full`  in  1  TX FIFO write side.
- `rxff_rd`  out  1, `rxff_data`  in  8, `rxff_empty`  in  1  RX FIFO read side; data is valid the cycle after `rxff_rd`.

## Operation
- States: IDLE, GRANT, LOAD, START, WAIT, DRAIN, FIN.
- IDLE → GRANT when any `req_valid`.
  - Winner is the first set bit searching upward from `rr_ptr`, wrapping at NREQ-1.
  - Latch owner, `core_addr_rw`, `core_cnt`, `core_div=cfg_div`, `left=req_cnt`.
- GRANT: `req_ready[owner]`=1 for exactly this cycle.
  - Write with `left`≠0 → LOAD; otherwise → START.
- LOAD: `wr_ready[owner] = !txff_full && left≠0`.
  - On accept: `txff_wr`=1, `txff_data=wr_data[owner]`, `left`-1.
  - → START when `left`=0 or `txff_full`, so the core is never starved on a shallow FIFO.
- START: `core_start`=1 for one cycle; clear the timeout counter; → WAIT.
- WAIT
  - Write: keep pushing as in LOAD while `left`≠0.
  - Read: `rxff_rd = !rxff_empty && left≠0 && !rd_pend`. `rd_pend` is set for one cycle after a read, so at most one read is in flight.
  - Next cycle: `rd_valid[owner]`=1, `rd_data=rxff_data`, `left`-1.
  - On `core_done`: → FIN if write, or if read with `left`=0; otherwise → DRAIN.
- DRAIN: read-only; continue reads until `left`=0; → FIN.
- FIN: `done[owner]`=1 for one cycle with `err`; `rr_ptr=(owner+1) mod NREQ`; → IDLE.
- Timeout: counter increments in WAIT/DRAIN. At `TIMEOUT` → FIN with `err`=1. Remaining bytes are abandoned; FIFO contents are not flushed by this block.
- `core_done` outside WAIT is ignored. `req_valid` changes for non-owners are ignored until IDLE.
- `left` is 8-bit; it never decrements below 0.

## Timing
- Reset (async assert, sync release): state IDLE, `rr_ptr`=0, every output 0, including `core_div`=16'h0000 and `rd_data`=8'h00.
- Grant latency: `req_valid` high in an IDLE cycle → `req_ready` in the next cycle (GRANT).
- Min write path for cnt=0: GRANT → START → WAIT, so `core_start` is 2 cycles after `req_ready`.
- Write throughput: 1 byte/cycle while `wr_valid` and not `txff_full`.
- Read throughput: 1 byte per 2 cycles.
- `done` is 1 cycle after the FIN condition. The next grant occurs no earlier than 2 cycles after `done`.
- Reset mid-transaction returns to IDLE immediately. No `done` is issued; the core and FIFOs are reset by the same `rst`.

## Test plan
- Write, req0 {0xA0, cnt=3}, bytes 11/22/33, FIFO not full → 3 `txff_wr` with 11,22,33, then `core_start`. Assert `core_done` 20 cycles later → `done[0]`=1, `err`=0.
- Read, req1 {0xA1, cnt=2}; RX FIFO supplies 5A, C3 (one before `core_done`, one after) → `rd_valid[1]` twice with 5A, C3 in order, then `done[1]`. No `rxff_rd` while `rxff_empty`.
- Both requesters valid after reset → req0 granted first, req1 second. Re-raise req0 → it is granted only after req1.
- Write cnt=8 with `txff_full` after 4 bytes → `core_start` after the 4th byte; the remaining 4 bytes are pushed as `txff_full` drops; `core_cnt`=8 throughout.
- TIMEOUT=100 and `core_done` never asserted → `done[owner]`=1 with `err`=1 exactly 100 cycles after WAIT entry; the next request is granted normally.
- Assert `rst` during LOAD → all outputs 0 asynchronously; no `done`; after release a fresh request is granted to requester 0.
